// File: rtl/tt_pin_cmd_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : tt_pin_cmd_responder_if
//  Description : Bundles the host pin handshake and the core register bus
//                used by tt_pin_cmd_responder.
//  Revision    : 1.0  initial release
// ============================================================================
interface tt_pin_cmd_responder_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;

  // Responder view: consumes pins and read data, drives responses and strobes.
  modport slave (
    input  ena, ui_in, uio_in, reg_rdata,
    output uo_out, uio_out, uio_oe, reg_addr, reg_wdata, reg_wr_en, reg_rd_en
  );

  // Host/core view: the opposite direction of every signal.
  modport master (
    output ena, ui_in, uio_in, reg_rdata,
    input  uo_out, uio_out, uio_oe, reg_addr, reg_wdata, reg_wr_en, reg_rd_en
  );
endinterface
`default_nettype wire

// File: rtl/tt_pin_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tt_pin_cmd_responder
//  Description : Decodes host command bytes received over a 4-phase req/ack
//                pin handshake into single-cycle register bus accesses.
//  Revision    : 1.0  initial release
// ============================================================================
module tt_pin_cmd_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  ID_BYTE     = 8'hA5
) (
  input logic                   clk,
  input logic                   rst_n,
  tt_pin_cmd_responder_if.slave bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_HDR_ACK    = 3'd1;
  localparam logic [2:0] S_WAIT_DATA  = 3'd2;
  localparam logic [2:0] S_DATA_ACK   = 3'd3;
  localparam logic [2:0] S_RD_ISSUE   = 3'd4;
  localparam logic [2:0] S_RD_CAPTURE = 3'd5;

  localparam logic [1:0] OP_ILLEGAL = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_PING    = 2'b11;

  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic [2:0]             state;
  logic [2:0]             state_next;
  logic [1:0]             hdr_op;
  logic                   is_write;
  logic                   ack;
  logic                   err;
  logic                   ack_state;
  logic                   rd_strobe;
  logic                   busy;
  logic [7:0]             resp;
  logic [5:0]             addr_q;
  logic [7:0]             wdata_q;
  logic                   wr_strobe;
  logic                   unused_uio;

  assign req_s      = req_sync[SYNC_STAGES-1];
  assign hdr_op     = bus.ui_in[7:6];
  assign unused_uio = ^bus.uio_in[7:1];

  // Bring the asynchronous host req into the clock domain; runs regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], bus.uio_in[0]};
    end
  end

  // State register; a low ena parks the machine in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (!bus.ena) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; every ack state waits for req to drop so a held req is consumed once.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (req_s) begin
          state_next = (hdr_op == OP_READ) ? S_RD_ISSUE : S_HDR_ACK;
        end
      end
      S_HDR_ACK: begin
        if (!req_s) begin
          state_next = is_write ? S_WAIT_DATA : S_IDLE;
        end
      end
      S_WAIT_DATA: begin
        if (req_s) begin
          state_next = S_DATA_ACK;
        end
      end
      S_DATA_ACK: begin
        if (!req_s) begin
          state_next = S_IDLE;
        end
      end
      S_RD_ISSUE:   state_next = S_RD_CAPTURE;
      S_RD_CAPTURE: state_next = S_HDR_ACK;
      default:      state_next = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    ack_state = (state == S_HDR_ACK) || (state == S_DATA_ACK);
    rd_strobe = (state == S_RD_ISSUE);
    busy      = (state != S_IDLE);
  end

  // Datapath: header latch, write strobe, response byte, sticky error and registered ack.
  // ack follows the ack states one clock late, giving symmetric rise/fall latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack       <= 1'b0;
      err       <= 1'b0;
      is_write  <= 1'b0;
      resp      <= 8'h00;
      addr_q    <= 6'd0;
      wdata_q   <= 8'h00;
      wr_strobe <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      ack       <= bus.ena & ack_state;
      if (bus.ena) begin
        case (state)
          S_IDLE: begin
            if (req_s) begin
              addr_q   <= bus.ui_in[5:0];
              is_write <= (hdr_op == OP_WRITE);
              if (hdr_op == OP_PING) begin
                resp <= ID_BYTE;
                err  <= 1'b0;
              end else if (hdr_op == OP_ILLEGAL) begin
                err <= 1'b1;
              end
            end
          end
          S_WAIT_DATA: begin
            if (req_s) begin
              wdata_q   <= bus.ui_in;
              wr_strobe <= 1'b1;
            end
          end
          S_RD_CAPTURE: resp <= bus.reg_rdata;
          default: ;
        endcase
      end
    end
  end

  assign bus.uo_out    = resp;
  assign bus.uio_out   = {4'b0000, err, busy, ack, 1'b0};
  assign bus.uio_oe    = 8'b0000_1110;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wr_en = wr_strobe;
  assign bus.reg_rd_en = rd_strobe;

endmodule
`default_nettype wire

// File: tb/tb_tt_pin_cmd_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_pin_cmd_responder
//  Description : Scoreboard bench for tt_pin_cmd_responder with a small
//                register-file model acting as the GOA core.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tt_pin_cmd_responder;

  localparam int K_WR  = 0;
  localparam int K_RD  = 1;
  localparam int K_ACK = 2;

  typedef struct {
    int         kind;
    logic [5:0] addr;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  logic [7:0] mem [64];
  logic ack_prev;

  tt_pin_cmd_responder_if pins ();

  tt_pin_cmd_responder #(
    .SYNC_STAGES (2),
    .ID_BYTE     (8'hA5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pins.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (pins.reg_rd_en) pins.reg_rdata <= mem[pins.reg_addr];
    if (pins.reg_wr_en) mem[pins.reg_addr] <= pins.reg_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [5:0] addr, input logic [7:0] data, input logic err);
    exp_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      case (kind)
        K_WR: begin
          chk("wr_addr", {26'd0, pins.reg_addr}, {26'd0, e.addr});
          chk("wr_data", {24'd0, pins.reg_wdata}, {24'd0, e.data});
        end
        K_RD: chk("rd_addr", {26'd0, pins.reg_addr}, {26'd0, e.addr});
        default: begin
          chk("ack_uo_out", {24'd0, pins.uo_out}, {24'd0, e.data});
          chk("ack_err", {31'd0, pins.uio_out[3]}, {31'd0, e.err});
        end
      endcase
    end
  endtask

  // Monitor: samples on the falling edge and checks every strobe and ack rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_prev = 1'b0;
    end else begin
      if (pins.reg_wr_en) observe(K_WR);
      if (pins.reg_rd_en) observe(K_RD);
      if (pins.uio_out[1] && !ack_prev) observe(K_ACK);
      ack_prev = pins.uio_out[1];
    end
  end

  // One full 4-phase handshake; hold keeps req high for extra cycles after ack.
  task automatic xfer(input logic [7:0] b, input int hold, output int lat_rise, output int lat_fall);
    int n;
    @(posedge clk); #1;
    pins.ui_in     = b;
    pins.uio_in[0] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!pins.uio_out[1] && n < 40);
    if (!pins.uio_out[1]) chk("ack_rise_timeout", 0, 1);
    lat_rise = n - 1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("stuck_ack_high", {30'd0, pins.uio_out[2:1]}, 32'd3);
    end
    pins.uio_in[0] = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (pins.uio_out[1] && n < 40);
    if (pins.uio_out[1]) chk("ack_fall_timeout", 1, 0);
    lat_fall = n - 1;
    pins.ui_in = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lr, lf, n;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[6'h12] = 8'h9E;
    pins.ena       = 1'b1;
    pins.ui_in     = 8'h00;
    pins.uio_in    = 8'h00;
    pins.reg_rdata = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uo_out", {24'd0, pins.uo_out}, 32'h00);
    chk("rst_uio_out", {24'd0, pins.uio_out}, 32'h00);
    chk("uio_oe", {24'd0, pins.uio_oe}, 32'h0E);
    chk("rst_reg_addr", {26'd0, pins.reg_addr}, 32'h00);
    chk("rst_strobes", {30'd0, pins.reg_wr_en, pins.reg_rd_en}, 32'h0);
    rst_n = 1'b1;

    // Write 0x3C to address 5.
    push(K_ACK, 6'd0, 8'h00, 1'b0);
    xfer(8'h45, 0, lr, lf);
    chk("hdr_ack_latency", lr, 3);
    chk("hdr_ack_fall_latency", lf, 3);
    push(K_WR, 6'd5, 8'h3C, 1'b0);
    push(K_ACK, 6'd0, 8'h00, 1'b0);
    xfer(8'h3C, 0, lr, lf);
    chk("data_ack_latency", lr, 3);
    chk("wr_uo_out_kept", {24'd0, pins.uo_out}, 32'h00);

    // Read address 0x12.
    push(K_RD, 6'h12, 8'h00, 1'b0);
    push(K_ACK, 6'd0, 8'h9E, 1'b0);
    xfer(8'h92, 0, lr, lf);
    chk("rd_ack_latency", lr, 5);
    chk("rd_ack_fall_latency", lf, 3);

    // Illegal op sets sticky err; ping clears it and returns the ID.
    push(K_ACK, 6'd0, 8'h9E, 1'b1);
    xfer(8'h00, 0, lr, lf);
    chk("err_sticky", {31'd0, pins.uio_out[3]}, 32'd1);
    push(K_ACK, 6'd0, 8'hA5, 1'b0);
    xfer(8'hC0, 0, lr, lf);
    chk("ping_uo_out", {24'd0, pins.uo_out}, 32'hA5);
    chk("ping_err_clear", {31'd0, pins.uio_out[3]}, 32'd0);

    // Write header with req held for 20 cycles, then reset while waiting for data.
    push(K_ACK, 6'd0, 8'hA5, 1'b0);
    xfer(8'h47, 20, lr, lf);
    @(posedge clk); #1;
    chk("wait_data_busy", {31'd0, pins.uio_out[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_uo_out", {24'd0, pins.uo_out}, 32'h00);
    chk("midrst_uio_out", {24'd0, pins.uio_out}, 32'h00);
    chk("midrst_reg_addr", {26'd0, pins.reg_addr}, 32'h00);
    #3;
    rst_n = 1'b1;

    // Fresh write after reset: 0x77 to address 1.
    push(K_ACK, 6'd0, 8'h00, 1'b0);
    xfer(8'h41, 0, lr, lf);
    push(K_WR, 6'd1, 8'h77, 1'b0);
    push(K_ACK, 6'd0, 8'h00, 1'b0);
    xfer(8'h77, 0, lr, lf);

    // Drop ena while the read strobe is out; nothing must be captured.
    push(K_RD, 6'h12, 8'h00, 1'b0);
    @(posedge clk); #1;
    pins.ui_in     = 8'h92;
    pins.uio_in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rd_issue_strobe", {31'd0, pins.reg_rd_en}, 32'd1);
    pins.ena = 1'b0;
    @(posedge clk); #1;
    chk("ena_low_idle", {30'd0, pins.uio_out[2:1]}, 32'd0);
    chk("ena_low_no_strobe", {31'd0, pins.reg_rd_en}, 32'd0);
    @(posedge clk); #1;
    chk("ena_low_uo_kept", {24'd0, pins.uo_out}, 32'h00);
    pins.uio_in[0] = 1'b0;
    pins.ui_in     = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    pins.ena = 1'b1;

    // Read back address 1 after re-enabling.
    push(K_RD, 6'd1, 8'h00, 1'b0);
    push(K_ACK, 6'd0, 8'h77, 1'b0);
    xfer(8'h81, 0, lr, lf);
    chk("rd2_ack_latency", lr, 5);
    chk("rd2_uo_out", {24'd0, pins.uo_out}, 32'h77);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    chk("scoreboard_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tt_pin_cmd_responder.md
Name: tt_pin_cmd_responder

Overview:
Pin-side command responder behind the Tiny Tapeout top-level pins of tt_um_scorbetta_goa. An external host drives command bytes on ui_in with a 4-phase req/ack handshake on uio pins. The block decodes write, read and ping commands into a simple single-cycle register bus toward the GOA core, and returns read data on uo_out.

Parameters:
SYNC_STAGES, 2, number of flops in the req input synchronizer (≥2).
ID_BYTE, 8'hA5, value returned on uo_out by a ping command.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  design enable; low forces FSM to IDLE synchronously
ui_in  in  8  host command/data byte; host holds it stable while req=1
uo_out  out  8  response byte (read data or ID_BYTE)
uio_in  in  8  bit0 = req from host; other bits ignored
uio_out  out  8  bit1=ack, bit2=busy, bit3=err; other bits 0
uio_oe  out  8  constant 8'b0000_1110
reg_addr  out  6  core register address
reg_wdata  out  8  core write data
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read strobe
reg_rdata  in  8  core read data, valid the cycle after reg_rd_en

Behaviour:
- Reset (async, rst_n=0): state IDLE; uo_out=0, ack=0, err=0, reg_addr=0, reg_wdata=0, reg_wr_en=0, reg_rd_en=0, synchronizer flops=0.
- req_s = uio_in[0] after SYNC_STAGES flops. ack is registered. busy = (state != IDLE).
- Header byte: op=ui_in[7:6], addr=ui_in[5:0]. op 01=write, 10=read, 11=ping, 00=illegal.
- States:
  - IDLE: ack=0. On req_s=1: latch header; set reg_addr=addr.
    - write -> HDR_ACK (next phase WAIT_DATA).
    - read -> RD_ISSUE.
    - ping -> uo_out<=ID_BYTE, err<=0, -> HDR_ACK.
    - illegal -> err<=1, -> HDR_ACK.
  - HDR_ACK: ack=1. Hold until req_s=0, then ack<=0 and go to WAIT_DATA (write) or IDLE (all others).
  - WAIT_DATA: on req_s=1, reg_wdata<=ui_in, reg_wr_en=1 for exactly one cycle, -> DATA_ACK.
  - DATA_ACK: ack=1 until req_s=0, then ack<=0, -> IDLE.
  - RD_ISSUE: reg_rd_en=1 for one cycle, -> RD_CAPTURE.
  - RD_CAPTURE: uo_out<=reg_rdata, -> HDR_ACK.
- Latency, counted in clocks from the edge at which req pin=1 is first sampled:
  - header/data ack rises SYNC_STAGES+1 clocks later.
  - read ack rises SYNC_STAGES+3 clocks later; uo_out is valid no later than ack.
  - ack falls SYNC_STAGES+1 clocks after req falls.
- uo_out holds its last value until overwritten by a read or ping; writes do not change it.
- A req held high across states is never double-consumed. Every byte needs a full req 1->0 cycle; WAIT_DATA only accepts after the header handshake has completed.
- ena=0: next edge forces IDLE, ack=0, strobes=0. uo_out and err are retained. Synchronizer keeps running.
- Reset asserted mid-transaction: immediate return to reset values. The host must restart from a header byte.
- err is sticky: set by an illegal op, cleared only by ping or reset.

Test Plan:
- Write: header 8'h45 (write, addr 5), then data 8'h3C -> exactly one reg_wr_en pulse with reg_addr=5, reg_wdata=8'h3C; two complete ack handshakes; uo_out unchanged.
- Read: core returns 8'h9E for addr 0x12; header 8'h92 -> one reg_rd_en pulse with reg_addr=0x12; uo_out=8'h9E when ack rises, SYNC_STAGES+3 clocks after req.
- Ping/error: header 8'h00 -> err=1 (uio_out[3]), no strobes; then header 8'hC0 -> uo_out=8'hA5, err=0.
- Stuck req: hold req=1 for 20 cycles after a write header -> ack stays 1, no reg_wr_en, state remains HDR_ACK until req drops.
- Reset mid-write: assert rst_n=0 while in WAIT_DATA -> all outputs at reset values within the same cycle; a new write 8'h41/8'h77 then completes normally.
- ena low: drop ena during RD_ISSUE -> IDLE next edge, ack=0, no uo_out update; after ena=1 a read 8'h81 returns correct data.
